// File: rtl/merge_arb_pkg.sv
// Shared types, widths and constants for the merge_arb native-bus merge.
// Response layout is {rdata[31:0], ready}; request layout is {valid, addr[, wdata, wstrb]}.
package merge_arb_pkg;

    typedef enum logic {
        BUS_I = 1'b0,
        BUS_D = 1'b1
    } bus_type_e;

    typedef enum logic {
        MERGE_IDLE = 1'b0,
        MERGE_BUSY = 1'b1
    } merge_state_e;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned RESP_W = DATA_W + 1;

    localparam logic [DATA_W-1:0] MERGE_TO_DATA = 32'hDEADBEEF;

    function automatic int unsigned bus_req_w(bus_type_e t, int unsigned addr_w);
        return (t == BUS_D) ? addr_w + DATA_W + STRB_W + 1 : addr_w + 1;
    endfunction

endpackage

// File: rtl/merge_arb_if.sv
// Bus bundle around merge_arb: N packed master request/response slices plus
// the single merged slave port.
interface merge_arb_if
    import merge_arb_pkg::*;
#(
    parameter int unsigned N_MASTERS = 2,
    parameter bus_type_e   TYPE      = BUS_D,
    parameter int unsigned ADDR_W    = 32
);
    localparam int unsigned REQ_W = bus_req_w(TYPE, ADDR_W);

    logic [N_MASTERS*REQ_W-1:0]  m_req;
    logic [N_MASTERS*RESP_W-1:0] m_resp;
    logic [REQ_W-1:0]            s_req;
    logic [RESP_W-1:0]           s_resp;

    modport slave (
        input  m_req,
        input  s_resp,
        output m_resp,
        output s_req
    );

    modport master (
        output m_req,
        output s_resp,
        input  m_resp,
        input  s_req
    );
endinterface

// File: rtl/merge_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit searching last+1, last+2, ...
// with wrap, built as rotate / find-first / un-rotate.
module rr_pick #(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [2*N-1:0] shifted;
    logic [N-1:0]   rot;
    int unsigned    first;
    int unsigned    src;

    always_comb begin
        shifted = {req, req} >> (32'(last) + 32'd1);
        rot     = shifted[N-1:0];
        first   = 0;
        for (int unsigned i = N; i > 0; i--) begin
            if (rot[i-1]) first = i - 1;
        end
        src = 32'(last) + 32'd1 + first;
        if (src >= N) src = src - N;
        idx = IW'(src);
        any = |req;
    end
endmodule

// File: rtl/merge_arb.sv
// N-to-1 native-bus merge with registered round-robin arbiter, one transaction in flight.
// Optional MERGE_ARB_TIMEOUT_EN adds a BUSY watchdog and the timeout port.
module merge_arb
    import merge_arb_pkg::*;
#(
    parameter int unsigned N_MASTERS = 2,
    parameter bus_type_e   TYPE      = BUS_D,
    parameter int unsigned ADDR_W    = 32
`ifdef MERGE_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_W = 8
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    merge_arb_if.slave  bus
`ifdef MERGE_ARB_TIMEOUT_EN
  , output logic        timeout
`endif
);
    localparam int unsigned REQ_W = bus_req_w(TYPE, ADDR_W);
    localparam int unsigned IW    = $clog2(N_MASTERS);

    merge_state_e state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_q, last_d;

    logic [N_MASTERS-1:0]        m_valid;
    logic [REQ_W-1:0]            g_req;
    logic                        g_valid;
    logic [IW-1:0]               pick_idx;
    logic                        pick_any;
    logic                        fwd;
    logic [RESP_W-1:0]           resp_val;
    logic [REQ_W-1:0]            s_req_c;
    logic [N_MASTERS*RESP_W-1:0] m_resp_c;
`ifdef MERGE_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 timeout_c;
`endif

    always_comb begin
        g_req = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            m_valid[i] = bus.m_req[i*REQ_W + REQ_W - 1];
            if (grant_q == IW'(i)) g_req = bus.m_req[i*REQ_W +: REQ_W];
        end
        g_valid = g_req[REQ_W-1];
    end

    rr_pick #(.N(N_MASTERS)) u_pick (
        .req  (m_valid),
        .last (last_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        s_req_c  = '0;
        fwd      = 1'b0;
        resp_val = bus.s_resp;
`ifdef MERGE_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_c = 1'b0;
`endif
        case (state_q)
            MERGE_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = MERGE_BUSY;
`ifdef MERGE_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            MERGE_BUSY: begin
                s_req_c = g_req;
`ifdef MERGE_ARB_TIMEOUT_EN
                cnt_d   = cnt_q + TIMEOUT_W'(1);
`endif
                // A master that drops valid abandons the transaction: no response, pointer kept.
                if (!g_valid) begin
                    state_d = MERGE_IDLE;
                end else begin
                    fwd = 1'b1;
                    if (bus.s_resp[0]) begin
                        last_d  = grant_q;
                        state_d = MERGE_IDLE;
                    end
`ifdef MERGE_ARB_TIMEOUT_EN
                    else if (cnt_q == '1) begin
                        resp_val  = {MERGE_TO_DATA, 1'b1};
                        s_req_c   = '0;
                        timeout_c = 1'b1;
                        last_d    = grant_q;
                        state_d   = MERGE_IDLE;
                    end
`endif
                end
            end
        endcase

        m_resp_c = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (fwd && grant_q == IW'(i)) m_resp_c[i*RESP_W +: RESP_W] = resp_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MERGE_IDLE;
            grant_q <= '0;
            last_q  <= IW'(N_MASTERS - 1);
`ifdef MERGE_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
`ifdef MERGE_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.s_req  = s_req_c;
    assign bus.m_resp = m_resp_c;
`ifdef MERGE_ARB_TIMEOUT_EN
    assign timeout = timeout_c;
`endif
endmodule

// File: tb/tb_merge_arb.sv
// Directed bench for merge_arb: 4 masters, D-type bus, hand-computed grant order.
module tb_merge_arb;
    import merge_arb_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned RW = bus_req_w(BUS_D, AW);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    merge_arb_if #(.N_MASTERS(N), .TYPE(BUS_D), .ADDR_W(AW)) bus ();

`ifdef MERGE_ARB_TIMEOUT_EN
    logic timeout;
`endif

    merge_arb #(
        .N_MASTERS (N),
        .TYPE      (BUS_D),
        .ADDR_W    (AW)
`ifdef MERGE_ARB_TIMEOUT_EN
      , .TIMEOUT_W (4)
`endif
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus)
`ifdef MERGE_ARB_TIMEOUT_EN
      , .timeout (timeout)
`endif
    );

    logic        mv [N];
    logic [31:0] ma [N];
    logic [31:0] mw [N];
    logic [3:0]  ms [N];

    always_comb begin
        bus.m_req = '0;
        for (int i = 0; i < N; i++) bus.m_req[i*RW +: RW] = {mv[i], ma[i], mw[i], ms[i]};
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] req_of(input int i);
        return {1'b1, ma[i], mw[i], ms[i]};
    endfunction

    function automatic logic [N*RESP_W-1:0] resp_vec(input int i, input logic [31:0] rd);
        logic [N*RESP_W-1:0] v;
        v = '0;
        v[i*RESP_W +: RESP_W] = {rd, 1'b1};
        return v;
    endfunction

    // Starts in IDLE with requests already driven; ends just after the edge back into IDLE.
    task automatic run_txn(input int idx, input int lat, input logic [31:0] rd, input string tag);
        #1;
        check({tag, " idle sreq"}, bus.s_req, '0);
        check({tag, " idle mresp"}, bus.m_resp, '0);
        tick;
        check({tag, " sreq"}, bus.s_req, req_of(idx));
        for (int k = 0; k < lat; k++) begin
            check({tag, " wait mresp"}, bus.m_resp, '0);
            tick;
        end
        bus.s_resp = {rd, 1'b1};
        #1;
        check({tag, " resp"}, bus.m_resp, resp_vec(idx, rd));
        tick;
        bus.s_resp = '0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        bus.s_resp = '0;
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0;
            ma[i] = 32'h4000_0000 + 32'(i) * 32'h100;
            mw[i] = 32'h1111_1111 * 32'(i + 1);
            ms[i] = 4'(i + 1);
        end

        // Reset and idle with no requests.
        tick;
        tick;
        check("reset sreq", bus.s_req, '0);
        check("reset mresp", bus.m_resp, '0);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick;
            check("idle sreq", bus.s_req, '0);
            check("idle mresp", bus.m_resp, '0);
        end

        // Single request from master 2.
        mv[2] = 1'b1;
        run_txn(2, 1, 32'h1234_5678, "single m2");
        mv[2] = 1'b0;

        // All four valid after reset: order 0,1,2,3,0.
        do_reset;
        for (int i = 0; i < N; i++) mv[i] = 1'b1;
        run_txn(0, 2, 32'h1000_0000, "rr0");
        run_txn(1, 2, 32'h1000_0001, "rr1");
        run_txn(2, 2, 32'h1000_0002, "rr2");
        run_txn(3, 2, 32'h1000_0003, "rr3");
        run_txn(0, 2, 32'h1000_0004, "rr0b");
        for (int i = 0; i < N; i++) mv[i] = 1'b0;

        // Masters 1 and 3 continuously requesting; last=0 so order 1,3,1,3.
        mw[1] = 32'hA5A5_0001; ms[1] = 4'hF;
        mw[3] = 32'hA5A5_0003; ms[3] = 4'hF;
        mv[1] = 1'b1;
        mv[3] = 1'b1;
        run_txn(1, 1, 32'h2000_0001, "alt1");
        run_txn(3, 1, 32'h2000_0003, "alt3");
        run_txn(1, 1, 32'h2000_0011, "alt1b");
        run_txn(3, 1, 32'h2000_0013, "alt3b");
        mv[1] = 1'b0;
        mv[3] = 1'b0;

        // Abort: last=3 so master 2 wins, then drops valid while a late ready arrives.
        mv[2] = 1'b1;
        #1;
        check("abort idle sreq", bus.s_req, '0);
        tick;
        check("abort sreq", bus.s_req, req_of(2));
        tick;
        mv[2] = 1'b0;
        bus.s_resp = {32'hCAFE_0000, 1'b1};
        #1;
        check("abort no resp", bus.m_resp, '0);
        tick;
        check("abort idle sreq2", bus.s_req, '0);
        check("idle ready ignored", bus.m_resp, '0);
        bus.s_resp = '0;
        // last still 3: search 0,1,2 picks 2 over 3.
        mv[2] = 1'b1;
        mv[3] = 1'b1;
        run_txn(2, 1, 32'h3000_0002, "after abort");
        mv[2] = 1'b0;
        mv[3] = 1'b0;

        // Reset mid-BUSY: last=2 so master 1 is granted, then reset hits.
        mv[1] = 1'b1;
        #1;
        tick;
        check("pre-reset sreq", bus.s_req, req_of(1));
        rst_n = 1'b0;
        bus.s_resp = {32'h5555_AAAA, 1'b1};
        #1;
        check("async reset sreq", bus.s_req, '0);
        check("async reset mresp", bus.m_resp, '0);
        tick;
        tick;
        mv[1] = 1'b0;
        bus.s_resp = '0;
        rst_n = 1'b1;
        // Reset restores last=3, so master 0 beats master 3.
        mv[0] = 1'b1;
        mv[3] = 1'b1;
        run_txn(0, 1, 32'h4000_0000, "post reset");
        mv[0] = 1'b0;
        mv[3] = 1'b0;

`ifdef MERGE_ARB_TIMEOUT_EN
        // last=0: master 1 granted, slave never ready, expiry on the 16th BUSY cycle.
        mv[1] = 1'b1;
        mv[2] = 1'b1;
        #1;
        check("to idle timeout", 256'(timeout), 256'(0));
        tick;
        check("to sreq", bus.s_req, req_of(1));
        for (int c = 1; c <= 15; c++) begin
            check("to wait mresp", bus.m_resp, '0);
            check("to wait timeout", 256'(timeout), 256'(0));
            tick;
        end
        check("to resp", bus.m_resp, resp_vec(1, 32'hDEADBEEF));
        check("to pulse", 256'(timeout), 256'(1));
        check("to sreq cleared", bus.s_req, '0);
        tick;
        check("to pulse end", 256'(timeout), 256'(0));
        run_txn(2, 1, 32'h6000_0002, "after timeout");
        mv[1] = 1'b0;
        mv[2] = 1'b0;
`endif

        tick;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
